timer_loader: RTL and testbench

//  Keypad-side writer for the microwave timer counter chain (mod-10 units, mod-6 tens, mod-10 mins).
//  - Collects BCD keystrokes into an M:SS entry register and validates it.
//  - Drives data/loadn to the counters, then gates their EN until timer_done or stop.
//  - Sits in the timer level between the keypad decoder and the counters.

---
 rtl/timer_loader.sv | 159 +++++++++++++++
 tb/tb_timer_loader.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_loader.sv
`default_nettype none
// ============================================================================
// Module      : timer_loader
// Description : Keypad-side writer for the microwave M:SS counter chain.
//               Collects BCD keys, validates start, pulses loadn, gates EN.
//               Optional pause on stop-in-RUN: define TIMER_LOADER_PAUSE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module timer_loader #(
    parameter int MAX_MINS = 9,
    parameter int LOAD_LEN = 1
) (
    input  logic       clk,
    input  logic       clear,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    input  logic       start,
    input  logic       stop,
    input  logic       timer_done,
    output logic [3:0] data_mins,
    output logic [3:0] data_tens,
    output logic [3:0] data_units,
    output logic       loadn,
    output logic       EN,
    output logic       err,
    output logic       done
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ENTRY = 3'd1,
        ST_LOAD  = 3'd2,
        ST_RUN   = 3'd3,
        ST_PAUSE = 3'd4
    } state_t;

    localparam logic [2:0] c_LOAD_LAST = 3'(LOAD_LEN - 1);
    localparam logic [3:0] c_MAX_MINS  = 4'(MAX_MINS);

    state_t     r_state;
    logic [3:0] r_m;
    logic [3:0] r_t;
    logic [3:0] r_u;
    logic [2:0] r_load_cnt;
    logic       r_loadn;
    logic       r_en;
    logic       r_err;
    logic       r_done;

    logic       w_key_ok;
    logic       w_entry_zero;
    logic       w_start_ok;

    assign w_key_ok     = key_valid && (key_code <= 4'd9);
    assign w_entry_zero = (r_m == 4'd0) && (r_t == 4'd0) && (r_u == 4'd0);
    assign w_start_ok   = (r_t <= 4'd5) && (r_m <= c_MAX_MINS) && !w_entry_zero;

    assign data_mins  = r_m;
    assign data_tens  = r_t;
    assign data_units = r_u;
    assign loadn      = r_loadn;
    assign EN         = r_en;
    assign err        = r_err;
    assign done       = r_done;

    // Each state branch tests its events in priority order: stop, timer_done, start, key.
    always_ff @(posedge clk) begin
        if (clear) begin
            r_state    <= ST_IDLE;
            r_m        <= 4'd0;
            r_t        <= 4'd0;
            r_u        <= 4'd0;
            r_load_cnt <= 3'd0;
            r_loadn    <= 1'b1;
            r_en       <= 1'b0;
            r_err      <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_err  <= 1'b0;
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_key_ok) begin
                        r_m     <= r_t;
                        r_t     <= r_u;
                        r_u     <= key_code;
                        r_state <= ST_ENTRY;
                    end
                end
                ST_ENTRY: begin
                    if (stop) begin
                        {r_m, r_t, r_u} <= 12'd0;
                        r_state         <= ST_IDLE;
                    end else if (start) begin
                        if (w_start_ok) begin
                            r_loadn    <= 1'b0;
                            r_load_cnt <= 3'd0;
                            r_state    <= ST_LOAD;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end else if (w_key_ok) begin
                        r_m <= r_t;
                        r_t <= r_u;
                        r_u <= key_code;
                    end
                end
                ST_LOAD: begin
                    if (stop) begin
                        r_loadn         <= 1'b1;
                        {r_m, r_t, r_u} <= 12'd0;
                        r_state         <= ST_IDLE;
                    end else if (r_load_cnt == c_LOAD_LAST) begin
                        // loadn rises and EN rises on the same edge, so they never overlap.
                        r_loadn <= 1'b1;
                        r_en    <= 1'b1;
                        r_state <= ST_RUN;
                    end else begin
                        r_load_cnt <= r_load_cnt + 3'd1;
                    end
                end
                ST_RUN: begin
                    if (stop) begin
                        r_en <= 1'b0;
`ifdef TIMER_LOADER_PAUSE_EN
                        r_state <= ST_PAUSE;
`else
                        {r_m, r_t, r_u} <= 12'd0;
                        r_state         <= ST_IDLE;
`endif
                    end else if (timer_done) begin
                        r_en            <= 1'b0;
                        r_done          <= 1'b1;
                        {r_m, r_t, r_u} <= 12'd0;
                        r_state         <= ST_IDLE;
                    end
                end
`ifdef TIMER_LOADER_PAUSE_EN
                ST_PAUSE: begin
                    if (stop) begin
                        {r_m, r_t, r_u} <= 12'd0;
                        r_state         <= ST_IDLE;
                    end else if (start) begin
                        r_en    <= 1'b1;
                        r_state <= ST_RUN;
                    end
                end
`endif
                default: begin
                    r_loadn <= 1'b1;
                    r_en    <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_timer_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_timer_loader
// Description : Scoreboard bench for timer_loader: directed scenarios then
//               random keypad traffic against a digit/mode reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_timer_loader;

    localparam int TB_MAX_MINS = 7;
    localparam int TB_LOAD_LEN = 2;

    logic       clk = 1'b0;
    logic       clear = 1'b0;
    logic       key_valid = 1'b0;
    logic [3:0] key_code = 4'd0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       timer_done = 1'b0;
    logic [3:0] data_mins;
    logic [3:0] data_tens;
    logic [3:0] data_units;
    logic       loadn;
    logic       EN;
    logic       err;
    logic       done;

    timer_loader #(
        .MAX_MINS (TB_MAX_MINS),
        .LOAD_LEN (TB_LOAD_LEN)
    ) dut (
        .clk        (clk),
        .clear      (clear),
        .key_valid  (key_valid),
        .key_code   (key_code),
        .start      (start),
        .stop       (stop),
        .timer_done (timer_done),
        .data_mins  (data_mins),
        .data_tens  (data_tens),
        .data_units (data_units),
        .loadn      (loadn),
        .EN         (EN),
        .err        (err),
        .done       (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] vec;
        string       tag;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    // Reference model: digits as integers, a coarse mode and a remaining-load count.
    typedef enum {M_IDLE, M_ENTRY, M_LOAD, M_RUN, M_PAUSE} mode_t;
    mode_t mode = M_IDLE;
    int    dm = 0, dt = 0, du = 0;
    int    load_left = 0;
    bit    m_err = 0, m_done = 0;

    task automatic wipe();
        dm = 0; dt = 0; du = 0;
    endtask

    task automatic model_step(input bit kv, input int kc, input bit st, input bit sp,
                              input bit td, input bit clr);
        bit key_ok;
        key_ok = kv && (kc <= 9);
        m_err  = 0;
        m_done = 0;
        if (clr) begin
            mode = M_IDLE;
            wipe();
        end else begin
            case (mode)
                M_IDLE: if (key_ok) begin
                    dm = dt; dt = du; du = kc; mode = M_ENTRY;
                end
                M_ENTRY: begin
                    if (sp) begin
                        wipe(); mode = M_IDLE;
                    end else if (st) begin
                        if (dt <= 5 && dm <= TB_MAX_MINS && (dm * 60 + dt * 10 + du) != 0) begin
                            mode = M_LOAD; load_left = TB_LOAD_LEN;
                        end else begin
                            m_err = 1;
                        end
                    end else if (key_ok) begin
                        dm = dt; dt = du; du = kc;
                    end
                end
                M_LOAD: begin
                    if (sp) begin
                        wipe(); mode = M_IDLE;
                    end else begin
                        load_left--;
                        if (load_left == 0) mode = M_RUN;
                    end
                end
                M_RUN: begin
                    if (sp) begin
`ifdef TIMER_LOADER_PAUSE_EN
                        mode = M_PAUSE;
`else
                        wipe(); mode = M_IDLE;
`endif
                    end else if (td) begin
                        m_done = 1; wipe(); mode = M_IDLE;
                    end
                end
                M_PAUSE: begin
                    if (sp) begin
                        wipe(); mode = M_IDLE;
                    end else if (st) begin
                        mode = M_RUN;
                    end
                end
                default: mode = M_IDLE;
            endcase
        end
    endtask

    task automatic cyc(input bit kv, input int kc, input bit st, input bit sp,
                       input bit td, input bit clr, input string tag);
        exp_t e;
        @(negedge clk);
        key_valid  = kv;
        key_code   = 4'(kc);
        start      = st;
        stop       = sp;
        timer_done = td;
        clear      = clr;
        model_step(kv, kc, st, sp, td, clr);
        e.vec = {4'(dm), 4'(dt), 4'(du), (mode != M_LOAD), (mode == M_RUN), m_err, m_done};
        e.tag = tag;
        exp_q.push_back(e);
    endtask

    task automatic key(input int d, input string tag);
        cyc(1, d, 0, 0, 0, 0, tag);
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, tag);
    endtask

    // Monitor: the DUT presents a full output vector every cycle.
    initial begin
        exp_t        e;
        logic [15:0] act;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                act = {data_mins, data_tens, data_units, loadn, EN, err, done};
                n_vec++;
                if (act !== e.vec) begin
                    n_bad++;
                    $display("FAIL %s: got m:t:u=%0h:%0h:%0h loadn=%b EN=%b err=%b done=%b, want m:t:u=%0h:%0h:%0h loadn=%b EN=%b err=%b done=%b",
                             e.tag, act[15:12], act[11:8], act[7:4], act[3], act[2], act[1], act[0],
                             e.vec[15:12], e.vec[11:8], e.vec[7:4], e.vec[3], e.vec[2], e.vec[1], e.vec[0]);
                end
            end
        end
    end

    initial begin
        cyc(0, 0, 0, 0, 0, 1, "reset");
        idle(1, "reset_hold");

        key(1, "t1_key"); key(3, "t1_key"); key(0, "t1_key");
        cyc(0, 0, 1, 0, 0, 0, "t1_start");
        idle(3, "t1_load_run");
        cyc(0, 0, 0, 0, 1, 0, "t1_done");
        idle(1, "t1_after");

        key(1, "t2_key"); key(7, "t2_key"); key(5, "t2_key");
        cyc(0, 0, 1, 0, 0, 0, "t2_reject");
        idle(1, "t2_hold");
        cyc(0, 0, 0, 1, 0, 0, "t2_stop");

        key(4, "t3_key"); key(2, "t3_key"); key(5, "t3_key"); key(9, "t3_key");
        key(12, "t3_badkey");
        cyc(0, 0, 0, 1, 0, 0, "t3_stop");

        key(4, "t4_key"); key(5, "t4_key");
        cyc(1, 8, 1, 0, 0, 0, "t4_start_key");
        idle(3, "t4_load_run");
        cyc(0, 0, 0, 1, 1, 0, "t4_stop_vs_done");
        idle(1, "t4_after");
        cyc(0, 0, 1, 0, 0, 0, "t4_start_pause");
        idle(1, "t4_resume");
        cyc(0, 0, 0, 1, 0, 0, "t4_stop");
        cyc(0, 0, 0, 1, 0, 0, "t4_stop2");

        key(1, "t5_key"); key(1, "t5_key"); key(0, "t5_key");
        cyc(0, 0, 1, 0, 0, 0, "t5_start");
        idle(3, "t5_run");
        cyc(0, 0, 0, 0, 0, 1, "t5_clear_run");
        cyc(0, 0, 1, 0, 0, 0, "t5_start_idle");

        key(8, "b_key"); key(0, "b_key"); key(0, "b_key");
        cyc(0, 0, 1, 0, 0, 0, "b_max_mins_reject");
        key(7, "b_key"); key(5, "b_key"); key(9, "b_key");
        cyc(0, 0, 1, 0, 0, 0, "b_max_accept");
        cyc(0, 0, 0, 1, 0, 0, "b_stop_in_load");
        key(0, "b_zero");
        cyc(0, 0, 1, 0, 0, 0, "b_zero_reject");
        key(0, "b_key"); key(1, "b_key");
        cyc(0, 0, 1, 0, 0, 0, "b_start_001");
        cyc(0, 0, 0, 0, 0, 1, "b_clear_in_load");

        for (int i = 0; i < 3000; i++) begin
            bit kv, st, sp, td, clr;
            kv  = ($urandom_range(0, 99) < 40);
            st  = ($urandom_range(0, 99) < 15);
            sp  = ($urandom_range(0, 99) < 5);
            td  = ($urandom_range(0, 99) < 10);
            clr = ($urandom_range(0, 199) == 0);
            cyc(kv, $urandom_range(0, 15), st, sp, td, clr, "random");
        end
        idle(2, "drain");

        repeat (4) @(posedge clk);
        #2;
        n_vec++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
